// File: rtl/max7219_cmd_sched.sv
// max7219_cmd_sched
// Command scheduler for a MAX7219 LED driver. It produces 16-bit serializer
// words {4'h0, addr[3:0], data[7:0]} over a valid/ready handshake and does three
// jobs:
//   - runs the power-up init sequence once i_en is high,
//   - refreshes digit registers 1..6 from a shadow copy of i_digits,
//   - rewrites the intensity register on request.
//
// Ports
//   i_clk, i_reset_n        : clock (rising edge), asynchronous active-low reset
//   i_en                    : enables command issue
//   i_update_stb            : one-cycle digit refresh request
//   i_digits[47:0]          : six segment bytes, digit k at [8k+7:8k]
//   i_intensity[3:0]        : brightness value
//   i_intensity_stb         : one-cycle intensity rewrite request
//   o_cmd[15:0]             : command word to the serializer
//   o_cmd_valid/i_cmd_ready : handshake; a command is accepted when both are high
//   o_busy                  : high when the state is not IDLE and not WAIT_EN
//   o_init_done             : high once the init sequence has been accepted
//
// state   | meaning
// WAIT_EN | waiting for i_en before running init
// INIT    | issuing the five init commands
// IDLE    | init done, waiting for refresh or intensity work
// DIGITS  | issuing digit registers 0x01..0x06 from the shadow copy
// INTENS  | issuing a single intensity command

module max7219_cmd_sched (
    input  logic        i_clk,
    input  logic        i_reset_n,
    input  logic        i_en,
    input  logic        i_update_stb,
    input  logic [47:0] i_digits,
    input  logic [3:0]  i_intensity,
    input  logic        i_intensity_stb,
    output logic [15:0] o_cmd,
    output logic        o_cmd_valid,
    input  logic        i_cmd_ready,
    output logic        o_busy,
    output logic        o_init_done
);

    localparam logic [2:0] WAIT_EN = 3'd0;
    localparam logic [2:0] INIT    = 3'd1;
    localparam logic [2:0] IDLE    = 3'd2;
    localparam logic [2:0] DIGITS  = 3'd3;
    localparam logic [2:0] INTENS  = 3'd4;

    logic [2:0]  state_q,     state_d;
    logic [2:0]  idx_q,       idx_d;
    logic [15:0] cmd_q,       cmd_d;
    logic        valid_q,     valid_d;
    logic        init_done_q, init_done_d;
    logic        upd_pend_q,  upd_pend_d;
    logic        int_pend_q,  int_pend_d;
    logic [47:0] shadow_q,    shadow_d;
    logic [3:0]  int_hold_q,  int_hold_d;

    logic        accept;
    logic [2:0]  idx_nxt;
    logic [3:0]  addr_nxt;

    function automatic logic [15:0] init_cmd(input logic [2:0] idx, input logic [3:0] inten);
        logic [15:0] c;
        case (idx)
            3'd0:    c = 16'h0F00;
            3'd1:    c = 16'h0B05;
            3'd2:    c = 16'h0900;
            3'd3:    c = {12'h0A0, inten};
            default: c = 16'h0C01;
        endcase
        return c;
    endfunction

    assign accept   = valid_q && i_cmd_ready;
    assign idx_nxt  = idx_q + 3'd1;
    assign addr_nxt = {1'b0, idx_nxt} + 4'd1;

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        cmd_d       = cmd_q;
        valid_d     = valid_q;
        init_done_d = init_done_q;
        upd_pend_d  = upd_pend_q;
        int_pend_d  = int_pend_q;
        shadow_d    = shadow_q;
        int_hold_d  = int_hold_q;

        case (state_q)
            WAIT_EN: begin
                if (i_en) begin
                    state_d    = INIT;
                    idx_d      = 3'd0;
                    cmd_d      = 16'h0F00;
                    valid_d    = 1'b1;
                    int_hold_d = i_intensity;
                end
            end
            INIT: begin
                if (accept) begin
                    if (idx_q == 3'd4) begin
                        init_done_d = 1'b1;
                        state_d     = IDLE;
                        valid_d     = 1'b0;
                    end else if (!i_en) begin
                        // Interrupted init: the next i_en starts over from 0x0F00.
                        state_d = WAIT_EN;
                        valid_d = 1'b0;
                    end else begin
                        idx_d = idx_nxt;
                        cmd_d = init_cmd(idx_nxt, int_hold_q);
                    end
                end
            end
            IDLE: begin
                if (i_en) begin
                    if (int_pend_q) begin
                        state_d = INTENS;
                        cmd_d   = {12'h0A0, int_hold_q};
                        valid_d = 1'b1;
                        // A refresh request arriving now must wait behind intensity.
                        if (i_update_stb) upd_pend_d = 1'b1;
                    end else if (upd_pend_q || i_update_stb) begin
                        // Pending and fresh requests merge into one frame.
                        state_d    = DIGITS;
                        idx_d      = 3'd0;
                        shadow_d   = i_digits;
                        cmd_d      = {8'h01, i_digits[7:0]};
                        valid_d    = 1'b1;
                        upd_pend_d = 1'b0;
                    end
                end
            end
            DIGITS: begin
                if (accept) begin
                    if (idx_q == 3'd5 || !i_en) begin
                        state_d = IDLE;
                        valid_d = 1'b0;
                    end else begin
                        idx_d = idx_nxt;
                        cmd_d = {4'h0, addr_nxt, shadow_q[{idx_nxt, 3'b000} +: 8]};
                    end
                end
            end
            INTENS: begin
                if (accept) begin
                    int_pend_d = 1'b0;
                    state_d    = IDLE;
                    valid_d    = 1'b0;
                end
            end
            default: begin
                state_d = WAIT_EN;
                valid_d = 1'b0;
            end
        endcase

        // Strobe capture comes last so a new intensity request in the same cycle
        // as an INTENS acceptance stays pending.
        if (i_en) begin
            if (i_intensity_stb) begin
                int_hold_d = i_intensity;
                int_pend_d = 1'b1;
            end
            if (i_update_stb && init_done_q && state_q != IDLE) upd_pend_d = 1'b1;
        end else begin
            upd_pend_d = 1'b0;
        end
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q     <= WAIT_EN;
            idx_q       <= 3'd0;
            cmd_q       <= 16'h0000;
            valid_q     <= 1'b0;
            init_done_q <= 1'b0;
            upd_pend_q  <= 1'b0;
            int_pend_q  <= 1'b0;
            shadow_q    <= 48'h0;
            int_hold_q  <= 4'h0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            cmd_q       <= cmd_d;
            valid_q     <= valid_d;
            init_done_q <= init_done_d;
            upd_pend_q  <= upd_pend_d;
            int_pend_q  <= int_pend_d;
            shadow_q    <= shadow_d;
            int_hold_q  <= int_hold_d;
        end
    end

    assign o_cmd       = cmd_q;
    assign o_cmd_valid = valid_q;
    assign o_busy      = (state_q != IDLE) && (state_q != WAIT_EN);
    assign o_init_done = init_done_q;

endmodule

// File: tb/tb_max7219_cmd_sched.sv
module tb_max7219_cmd_sched;

    logic        clk;
    logic        rst_n;
    logic        en;
    logic        upd_stb;
    logic [47:0] digits;
    logic [3:0]  intensity;
    logic        int_stb;
    logic [15:0] cmd;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        busy;
    logic        init_done;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    logic [15:0] acc_q[$];
    int          acc_cyc[$];

    max7219_cmd_sched dut (
        .i_clk           (clk),
        .i_reset_n       (rst_n),
        .i_en            (en),
        .i_update_stb    (upd_stb),
        .i_digits        (digits),
        .i_intensity     (intensity),
        .i_intensity_stb (int_stb),
        .o_cmd           (cmd),
        .o_cmd_valid     (cmd_valid),
        .i_cmd_ready     (cmd_ready),
        .o_busy          (busy),
        .o_init_done     (init_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Records every accepted command; inputs change 1 ns after the rising edge,
    // so at the falling edge valid/ready reflect what the next rising edge sees.
    always @(negedge clk) begin
        if (rst_n && cmd_valid && cmd_ready) begin
            acc_q.push_back(cmd);
            acc_cyc.push_back(cyc);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; en = 1'b1; intensity = 4'h7; cmd_ready = 1'b1;
        repeat (3) tick();
        checks++; if (cmd !== 16'h0000) begin errors++; $display("FAIL reset_cmd: got %h expected 0000", cmd); end
        checks++; if (cmd_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", cmd_valid); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
        checks++; if (init_done !== 1'b0) begin errors++; $display("FAIL reset_init_done: got %b expected 0", init_done); end
    endtask

    task automatic test_init();
        logic [15:0] exp_c [0:4];
        exp_c[0] = 16'h0F00; exp_c[1] = 16'h0B05; exp_c[2] = 16'h0900;
        exp_c[3] = 16'h0A07; exp_c[4] = 16'h0C01;
        rst_n = 1'b1;
        for (int k = 0; k < 5; k++) begin
            tick();
            checks++;
            if (cmd_valid !== 1'b1 || cmd !== exp_c[k]) begin
                errors++;
                $display("FAIL init_cmd%0d: got valid=%b cmd=%h expected valid=1 cmd=%h", k, cmd_valid, cmd, exp_c[k]);
            end
            checks++; if (init_done !== 1'b0) begin errors++; $display("FAIL init_done_early%0d: got %b expected 0", k, init_done); end
        end
        tick();
        checks++; if (init_done !== 1'b1) begin errors++; $display("FAIL init_done: got %b expected 1", init_done); end
        checks++; if (cmd_valid !== 1'b0) begin errors++; $display("FAIL init_valid_off: got %b expected 0", cmd_valid); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL init_busy_off: got %b expected 0", busy); end
    endtask

    task automatic test_digits();
        logic [15:0] exp_c [0:5];
        logic [15:0] got;
        exp_c[0] = 16'h015B; exp_c[1] = 16'h0279; exp_c[2] = 16'h036D;
        exp_c[3] = 16'h0436; exp_c[4] = 16'h0530; exp_c[5] = 16'h067E;
        acc_q.delete(); acc_cyc.delete();
        digits = 48'h7E3036_6D795B; upd_stb = 1'b1;
        tick();
        upd_stb = 1'b0; digits = 48'h1111_1111_1111;
        checks++;
        if (cmd_valid !== 1'b1 || cmd !== 16'h015B) begin
            errors++; $display("FAIL dig_first: got valid=%b cmd=%h expected valid=1 cmd=015B", cmd_valid, cmd);
        end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL dig_busy: got %b expected 1", busy); end
        repeat (10) tick();
        checks++; if (acc_q.size() != 6) begin errors++; $display("FAIL dig_count: got %0d expected 6", acc_q.size()); end
        for (int i = 0; i < 6; i++) begin
            got = (i < acc_q.size()) ? acc_q[i] : 16'hFFFF;
            checks++; if (got !== exp_c[i]) begin errors++; $display("FAIL dig_cmd%0d: got %h expected %h", i, got, exp_c[i]); end
        end
        if (acc_cyc.size() == 6) begin
            checks++;
            if (acc_cyc[5] - acc_cyc[0] != 5) begin
                errors++; $display("FAIL dig_back_to_back: got span %0d expected 5", acc_cyc[5] - acc_cyc[0]);
            end
        end
        checks++; if (cmd_valid !== 1'b0) begin errors++; $display("FAIL dig_valid_off: got %b expected 0", cmd_valid); end
    endtask

    task automatic test_ready_toggle();
        logic [15:0] exp_c [0:5];
        logic [15:0] got, pc;
        logic        pv, pr;
        exp_c[0] = 16'h0106; exp_c[1] = 16'h0205; exp_c[2] = 16'h0304;
        exp_c[3] = 16'h0403; exp_c[4] = 16'h0502; exp_c[5] = 16'h0601;
        acc_q.delete(); acc_cyc.delete();
        digits = 48'h0102_0304_0506;
        for (int k = 0; k < 30; k++) begin
            cmd_ready = (k % 3 == 2);
            upd_stb = (k == 0);
            pv = cmd_valid; pr = cmd_ready; pc = cmd;
            tick();
            if (pv && !pr) begin
                checks++;
                if (cmd_valid !== 1'b1 || cmd !== pc) begin
                    errors++; $display("FAIL rdy_hold%0d: got valid=%b cmd=%h expected valid=1 cmd=%h", k, cmd_valid, cmd, pc);
                end
            end
        end
        upd_stb = 1'b0; cmd_ready = 1'b1;
        checks++; if (acc_q.size() != 6) begin errors++; $display("FAIL rdy_count: got %0d expected 6", acc_q.size()); end
        for (int i = 0; i < 6; i++) begin
            got = (i < acc_q.size()) ? acc_q[i] : 16'hFFFF;
            checks++; if (got !== exp_c[i]) begin errors++; $display("FAIL rdy_cmd%0d: got %h expected %h", i, got, exp_c[i]); end
        end
    endtask

    task automatic test_pending();
        logic [15:0] exp_c [0:12];
        logic [15:0] got;
        exp_c[0]  = 16'h01A6; exp_c[1]  = 16'h02A5; exp_c[2]  = 16'h03A4;
        exp_c[3]  = 16'h04A3; exp_c[4]  = 16'h05A2; exp_c[5]  = 16'h06A1;
        exp_c[6]  = 16'h0A0C;
        exp_c[7]  = 16'h01B6; exp_c[8]  = 16'h02B5; exp_c[9]  = 16'h03B4;
        exp_c[10] = 16'h04B3; exp_c[11] = 16'h05B2; exp_c[12] = 16'h06B1;
        acc_q.delete(); acc_cyc.delete();
        digits = 48'hA1A2_A3A4_A5A6; upd_stb = 1'b1;
        tick();
        digits = 48'hB1B2_B3B4_B5B6;
        tick();
        int_stb = 1'b1; intensity = 4'hC;
        tick();
        int_stb = 1'b0;
        tick();
        upd_stb = 1'b0;
        repeat (40) tick();
        checks++; if (acc_q.size() != 13) begin errors++; $display("FAIL pend_count: got %0d expected 13", acc_q.size()); end
        for (int i = 0; i < 13; i++) begin
            got = (i < acc_q.size()) ? acc_q[i] : 16'hFFFF;
            checks++; if (got !== exp_c[i]) begin errors++; $display("FAIL pend_cmd%0d: got %h expected %h", i, got, exp_c[i]); end
        end
    endtask

    task automatic test_en_drop();
        logic [15:0] got;
        acc_q.delete(); acc_cyc.delete();
        cmd_ready = 1'b1;
        digits = 48'hC1C2_C3C4_C5C6; upd_stb = 1'b1;
        tick();
        tick();
        upd_stb = 1'b0;
        tick();
        cmd_ready = 1'b0; en = 1'b0;
        for (int k = 0; k < 2; k++) begin
            tick();
            checks++;
            if (cmd_valid !== 1'b1 || cmd !== 16'h03C4) begin
                errors++; $display("FAIL en_hold%0d: got valid=%b cmd=%h expected valid=1 cmd=03C4", k, cmd_valid, cmd);
            end
        end
        cmd_ready = 1'b1;
        tick();
        checks++; if (cmd_valid !== 1'b0) begin errors++; $display("FAIL en_valid_off: got %b expected 0", cmd_valid); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL en_busy_off: got %b expected 0", busy); end
        upd_stb = 1'b1;
        tick();
        upd_stb = 1'b0;
        repeat (3) tick();
        checks++; if (cmd_valid !== 1'b0) begin errors++; $display("FAIL en_low_strobe: got valid %b expected 0", cmd_valid); end
        en = 1'b1;
        repeat (10) tick();
        checks++; if (acc_q.size() != 3) begin errors++; $display("FAIL en_count: got %0d expected 3", acc_q.size()); end
        got = (acc_q.size() >= 3) ? acc_q[2] : 16'hFFFF;
        checks++; if (got !== 16'h03C4) begin errors++; $display("FAIL en_last_cmd: got %h expected 03C4", got); end
    endtask

    task automatic test_reset_mid();
        logic [15:0] exp_c [0:4];
        logic [15:0] got;
        exp_c[0] = 16'h0F00; exp_c[1] = 16'h0B05; exp_c[2] = 16'h0900;
        exp_c[3] = 16'h0A05; exp_c[4] = 16'h0C01;
        rst_n = 1'b0; intensity = 4'h5; cmd_ready = 1'b1; en = 1'b1;
        tick();
        rst_n = 1'b1;
        repeat (4) tick();
        checks++;
        if (cmd_valid !== 1'b1 || cmd !== 16'h0A05) begin
            errors++; $display("FAIL rst_pre: got valid=%b cmd=%h expected valid=1 cmd=0A05", cmd_valid, cmd);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++; if (cmd_valid !== 1'b0) begin errors++; $display("FAIL rst_async_valid: got %b expected 0", cmd_valid); end
        checks++; if (cmd !== 16'h0000) begin errors++; $display("FAIL rst_async_cmd: got %h expected 0000", cmd); end
        #2 rst_n = 1'b1;
        acc_q.delete(); acc_cyc.delete();
        tick();
        checks++;
        if (cmd_valid !== 1'b1 || cmd !== 16'h0F00) begin
            errors++; $display("FAIL rst_restart: got valid=%b cmd=%h expected valid=1 cmd=0F00", cmd_valid, cmd);
        end
        repeat (8) tick();
        checks++; if (acc_q.size() != 5) begin errors++; $display("FAIL rst_count: got %0d expected 5", acc_q.size()); end
        for (int i = 0; i < 5; i++) begin
            got = (i < acc_q.size()) ? acc_q[i] : 16'hFFFF;
            checks++; if (got !== exp_c[i]) begin errors++; $display("FAIL rst_cmd%0d: got %h expected %h", i, got, exp_c[i]); end
        end
        checks++; if (init_done !== 1'b1) begin errors++; $display("FAIL rst_init_done: got %b expected 1", init_done); end
    endtask

    initial begin
        rst_n = 1'b0; en = 1'b0; upd_stb = 1'b0; int_stb = 1'b0;
        digits = 48'h0; intensity = 4'h0; cmd_ready = 1'b1;
        test_reset();
        test_init();
        test_digits();
        test_ready_toggle();
        test_pending();
        test_en_drop();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/max7219_cmd_sched.md
MAX7219_CMD_SCHED -- requirements
Module: max7219_cmd_sched

Interface
REQ-001 SHALL have port i_clk, input, 1 bit: the single system clock; all state changes on its rising edge.
REQ-002 SHALL have port i_reset_n, input, 1 bit: reset, asynchronous and active-low.
REQ-003 SHALL have port i_en, input, 1 bit: enables command issue.
REQ-004 SHALL have port i_update_stb, input, 1 bit: one-cycle request for a digit refresh.
REQ-005 SHALL have port i_digits, input, 48 bits: six segment bytes; digit k is at [8k+7:8k], k = 0..5.
REQ-006 SHALL have port i_intensity, input, 4 bits: display brightness.
REQ-007 SHALL have port i_intensity_stb, input, 1 bit: one-cycle request to rewrite the intensity.
REQ-008 SHALL have port o_cmd, output, 16 bits: serializer word {4'h0, addr[3:0], data[7:0]}.
REQ-009 SHALL have port o_cmd_valid, output, 1 bit: o_cmd is valid.
REQ-010 SHALL have port i_cmd_ready, input, 1 bit: the serializer accepts o_cmd.
REQ-011 SHALL have port o_busy, output, 1 bit: high in every state except IDLE and WAIT_EN.
REQ-012 SHALL have port o_init_done, output, 1 bit: high once the init sequence has completed.

Function
REQ-013 SHALL implement the states WAIT_EN, INIT, IDLE, DIGITS and INTENS.
REQ-014 SHALL treat a command as accepted in the cycle where o_cmd_valid and i_cmd_ready are both high.
REQ-015 SHALL hold o_cmd constant while o_cmd_valid is high and not yet accepted.
REQ-016 SHALL, when a further command follows an acceptance, present that command with o_cmd_valid high in the next cycle (back-to-back, no gap).
REQ-017 SHALL deassert o_cmd_valid in the cycle after acceptance of the last command of a sequence.
REQ-018 SHALL go from WAIT_EN to INIT on the first edge with i_en=1, and at that edge capture i_intensity.
REQ-019 SHALL raise o_cmd_valid for the first INIT command in the cycle after the WAIT_EN->INIT edge.
REQ-020 SHALL issue the INIT commands in this order: 0x0F00 (test off), 0x0B05 (scan limit: 6 digits), 0x0900 (no decode), 0x0A0v (v = captured intensity), 0x0C01 (normal operation).
REQ-021 SHALL set o_init_done on acceptance of 0x0C01 and then enter IDLE; o_init_done stays high until reset.
REQ-022 SHALL, when i_update_stb is high in IDLE, copy i_digits into a 48-bit shadow register and enter DIGITS.
REQ-023 SHALL raise o_cmd_valid with o_cmd = 0x01 and digit0 in the cycle after the update strobe.
REQ-024 SHALL, in DIGITS, issue addresses 0x01..0x06 in order, with data taken from the shadow register only.
REQ-025 SHALL ignore changes to i_digits during a frame.
REQ-026 SHALL, on i_intensity_stb, capture i_intensity into a holding register and set the intensity-pending flag; a later strobe overwrites the held value.
REQ-027 SHALL, when i_update_stb occurs while not in IDLE but after init is done, set a one-deep update-pending flag; repeated strobes collapse into that flag.
REQ-028 SHALL, in IDLE, give intensity-pending priority over update-pending.
REQ-029 SHALL send intensity-pending as the single command 0x0A0v (state INTENS) and clear the flag on acceptance.
REQ-030 SHALL service update-pending exactly like a fresh strobe, latching i_digits at the moment of leaving IDLE.
REQ-031 SHALL, when a strobe and a pending flag of the same kind coincide, produce no duplicate command.
REQ-032 SHALL ignore i_update_stb before o_init_done is high.
REQ-033 SHALL latch i_intensity_stb before o_init_done is high; INIT then re-sends nothing extra.
REQ-034 SHALL, when i_en is low with o_cmd_valid high, still complete the outstanding handshake.
REQ-035 SHALL, after that handshake, issue no further commands and go to WAIT_EN if init was not done, else to IDLE.
REQ-036 SHALL, while i_en is low, clear update-pending, keep intensity-pending, and ignore strobes.
REQ-037 SHALL, on the first edge with i_en=1 after an INIT interrupted by i_en, restart INIT from 0x0F00.

Reset
REQ-038 SHALL, while i_reset_n=0, immediately force o_cmd=0, o_cmd_valid=0, o_busy=0, o_init_done=0, state=WAIT_EN, both pending flags=0, shadow register=0 and held intensity=0.
REQ-039 SHALL, when reset is asserted mid-sequence, abandon the in-flight command, which is never re-issued; after release INIT restarts.

Verification
REQ-040 SHALL cover: reset release with i_en=1, i_intensity=7, ready tied 1 -> valid from cycle 1; exactly 0x0F00, 0x0B05, 0x0900, 0x0A07, 0x0C01 on 5 consecutive cycles; o_init_done=1 on the 6th.
REQ-041 SHALL cover: after init, i_digits=0x7E3036_6D795B with i_update_stb -> 0x015B, 0x0279, 0x036D, 0x0436, 0x0530, 0x067E; exactly six accepts; i_digits changed mid-frame is not used.
REQ-042 SHALL cover: ready toggling 1-of-3 cycles -> o_cmd stable while valid and unaccepted; order and count unchanged.
REQ-043 SHALL cover: three update strobes plus intensity_stb (i_intensity=0xC) during a frame -> the frame completes, then 0x0A0C, then exactly one further six-command frame.
REQ-044 SHALL cover: i_en dropped during the 3rd digit with ready=0 -> valid held until accepted, then deasserts; no 4th digit; update-pending discarded.
REQ-045 SHALL cover: i_reset_n pulsed low during the 4th INIT command -> valid drops asynchronously; after release the sequence restarts at 0x0F00.
